// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART serializer among byte-stream requesters.
// An owner keeps the grant for a whole packet or until the burst cap is reached.
module uart_tx_sched #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 16
) (
  input  logic                 ser_clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*8-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ack,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {
    S_IDLE,
    S_LOCKED
  } state_e;

  state_e               state_q;
  logic [NUM_REQ-1:0]   grant_q;
  logic [IW-1:0]        owner_q;
  logic [IW-1:0]        last_q;
  logic [CW-1:0]        cnt_q;
  logic [CW-1:0]        cnt_d;

  logic [IW-1:0]        pick;
  logic [IW-1:0]        cand;
  logic                 found;
  logic [7:0]           own_data;
  logic                 own_req;
  logic                 own_last;
  logic                 locked;
  logic                 xfer;
  logic                 cap;
  logic                 release_now;

  // Scan last+1, last+2, ... wrapping; the first set bit wins.
  always_comb begin
    pick  = last_q;
    cand  = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IW'((int'(last_q) + k) % NUM_REQ);
      if (!found && req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    own_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) own_data = own_data | req_data[8*i +: 8];
    end
  end

  assign own_req  = |(req & grant_q);
  assign own_last = |(req_last & grant_q);
  assign locked   = (state_q == S_LOCKED);

  // Reset cycle never consumes a byte.
  assign tx_valid = locked && own_req && !rst;
  assign xfer     = tx_valid && tx_ready;
  assign tx_data  = own_data;
  assign req_ack  = xfer ? grant_q : '0;
  assign grant    = grant_q;
  assign busy     = locked;

  assign cnt_d       = cnt_q + 1'b1;
  assign cap         = (cnt_d == CW'(MAX_BURST));
  assign release_now = !own_req || (xfer && (own_last || cap));

  always_ff @(posedge ser_clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      owner_q <= '0;
      last_q  <= IW'(NUM_REQ - 1);
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (|req) begin
            grant_q <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick;
            owner_q <= pick;
            cnt_q   <= '0;
            state_q <= S_LOCKED;
          end
        end
        S_LOCKED: begin
          if (release_now) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            last_q  <= owner_q;
            cnt_q   <= '0;
          end else if (xfer) begin
            cnt_q <= cnt_d;
          end
        end
        default: begin
          state_q <= S_IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

endmodule
